// File: rtl/dsram_axi_bridge_pkg.sv
// dsram_axi_bridge_pkg: state encoding, AXI constants and size mapping shared by the data-side bridge
package dsram_axi_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  function automatic logic [2:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction
endpackage

// File: rtl/dsram_axi_bridge.sv
// dsram_axi_bridge: SRAM-like data port to single-beat AXI4 master, one transaction in flight.
// Define DSRAM_BRIDGE_ERR_EN to add data_sram_err, flagging SLVERR/DECERR alongside data_ok.
module dsram_axi_bridge
  import dsram_axi_bridge_pkg::*;
#(
  parameter int RD_ID = 1,
  parameter int WR_ID = 1,
  parameter int ID_W  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [31:0]     data_sram_addr,
  input  logic [3:0]      data_sram_wstrb,
  input  logic [31:0]     data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [31:0]     data_sram_rdata,
`ifdef DSRAM_BRIDGE_ERR_EN
  output logic            data_sram_err,
`endif
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        err_q, err_d;
  logic        unused_ok;

  // ids, rlast and the low response bit carry nothing the core needs
  assign unused_ok = ^{rid, rlast, bid, rresp, bresp, err_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (data_sram_req) begin
        addr_d    = data_sram_addr;
        size_d    = data_sram_size;
        wstrb_d   = data_sram_wstrb;
        wdata_d   = data_sram_wdata;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = data_sram_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: state_d = arready ? RD_DATA : RD_ADDR;
      RD_DATA: if (rvalid) begin
        rdata_d = rdata;
        err_d   = rresp[1];
        state_d = DONE;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bvalid) begin
        err_d   = bresp[1];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  assign data_sram_addr_ok = (state_q == IDLE) && data_sram_req;
  assign data_sram_data_ok = state_q == DONE;
  assign data_sram_rdata   = rdata_q;
`ifdef DSRAM_BRIDGE_ERR_EN
  assign data_sram_err     = err_q;
`endif

  assign arid    = ID_W'(RD_ID);
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = to_axsize(size_q);
  assign arburst = BURST_INCR;
  assign arvalid = state_q == RD_ADDR;
  assign rready  = state_q == RD_DATA;

  // each write channel drops its valid after its own handshake
  assign awid    = ID_W'(WR_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = to_axsize(size_q);
  assign awburst = BURST_INCR;
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign bready  = state_q == WR_RESP;
endmodule

// File: tb/tb_dsram_axi_bridge.sv
// tb_dsram_axi_bridge: randomized scoreboard bench with a memory-backed AXI slave and a reference memory.
module tb_dsram_axi_bridge;
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic data_sram_req = 1'b0, data_sram_wr = 1'b0;
  logic [1:0] data_sram_size = '0;
  logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
  logic [3:0] data_sram_wstrb = '0;
  logic data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
`ifdef DSRAM_BRIDGE_ERR_EN
  logic data_sram_err;
`endif
  logic [3:0] arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  dsram_axi_bridge dut (
    .clk(clk), .rstn(rstn),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
`ifdef DSRAM_BRIDGE_ERR_EN
    .data_sram_err(data_sram_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  txn_t txn_q[$], exp_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] smem [logic [29:0]];
  int issued = 0, dok_cnt = 0;
  logic [31:0] last_rd = '0;
  bit rnd = 1'b0, b_hold = 1'b0;
  int ar_block = 0, aw_block = 0, ar_cycles = 0, aw_cycles = 0, w_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] mem_get(input bit slave, input logic [29:0] a);
    if (slave) return smem.exists(a) ? smem[a] : init_word(a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // AXI slave: memory-backed, optional random stalls, checks request fields against the issued transaction
  initial begin
    int r_cnt = -1, b_cnt = -1;
    bit r_drop = 0, b_drop = 0, aw_seen = 0, w_seen = 0, b_phase = 0, ar_stall = 0;
    logic [31:0] prev_araddr = '0, aw_addr = '0, w_data = '0, r_addr = '0;
    logic [3:0] w_strb = '0;
    txn_t t;
    {arready, awready, wready, rvalid, bvalid, rlast} = '0;
    rid = '0; bid = '0; rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        {arready, awready, wready, rvalid, bvalid} = '0;
        r_cnt = -1; b_cnt = -1;
        {r_drop, b_drop, aw_seen, w_seen, b_phase, ar_stall} = '0;
        continue;
      end
      if (r_drop) begin rvalid = 0; r_drop = 0; end
      if (b_drop) begin bvalid = 0; b_drop = 0; end
      if (!rvalid && r_cnt > 0) r_cnt--;
      else if (!rvalid && r_cnt == 0) begin
        rvalid = 1; rdata = mem_get(1, r_addr[31:2]); rlast = 1;
        rresp = txn_q.size() != 0 ? txn_q[0].resp : 2'b00; rid = 4'($urandom); r_cnt = -1;
      end
      if (!bvalid && !b_hold && b_cnt > 0) b_cnt--;
      else if (!bvalid && !b_hold && b_cnt == 0) begin
        bvalid = 1; bresp = txn_q.size() != 0 ? txn_q[0].resp : 2'b00; bid = 4'($urandom); b_cnt = -1;
      end
      arready = ar_block > 0 ? 1'b0 : (rnd ? $urandom_range(0, 2) != 0 : 1'b1);
      if (ar_block > 0 && arvalid) ar_block--;
      awready = aw_block > 0 ? 1'b0 : (rnd ? $urandom_range(0, 2) != 0 : 1'b1);
      if (aw_block > 0 && awvalid) aw_block--;
      wready = rnd ? $urandom_range(0, 2) != 0 : 1'b1;
      ar_cycles += int'(arvalid); aw_cycles += int'(awvalid); w_cycles += int'(wvalid);
      if (ar_stall) begin
        chk("arvalid_hold", 32'(arvalid), 1);
        chk("araddr_hold", araddr, prev_araddr);
      end
      ar_stall = arvalid && !arready;
      prev_araddr = araddr;
      if (arvalid || awvalid) chk("ar_aw_overlap", 32'(arvalid && awvalid), 0);
      if (bready) chk("bready_early", 32'(b_phase), 1);
      t = txn_q.size() != 0 ? txn_q[0] : '{default: '0};
      if (arvalid && arready) begin
        chk("ar_expected", 32'(txn_q.size() != 0 && !t.wr), 1);
        chk("araddr", araddr, t.addr);
        chk("arsize", 32'(arsize), 32'({1'b0, t.size}));
        chk("ar_len_burst_id", {12'd0, arid, arlen, 6'd0, arburst}, {12'd0, 4'd1, 8'd0, 6'd0, 2'b01});
        r_addr = araddr;
        r_cnt = rnd ? $urandom_range(0, 2) : 0;
      end
      if (awvalid && awready) begin
        chk("aw_expected", 32'(txn_q.size() != 0 && t.wr), 1);
        chk("awaddr", awaddr, t.addr);
        chk("awsize", 32'(awsize), 32'({1'b0, t.size}));
        chk("aw_len_burst_id", {12'd0, awid, awlen, 6'd0, awburst}, {12'd0, 4'd1, 8'd0, 6'd0, 2'b01});
        aw_seen = 1; aw_addr = awaddr;
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, t.wdata);
        chk("wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, t.wstrb, 1'b1});
        w_seen = 1; w_data = wdata; w_strb = wstrb;
      end
      if (aw_seen && w_seen) begin
        smem[aw_addr[31:2]] = merge(mem_get(1, aw_addr[31:2]), w_data, w_strb);
        aw_seen = 0; w_seen = 0; b_phase = 1;
        b_cnt = rnd ? $urandom_range(0, 2) : 0;
      end
      if (rvalid && rready) begin r_drop = 1; if (txn_q.size() != 0) void'(txn_q.pop_front()); end
      if (bvalid && bready) begin b_drop = 1; b_phase = 0; if (txn_q.size() != 0) void'(txn_q.pop_front()); end
    end
  end

  // monitor: pops the scoreboard on every data_ok and polices the handshake rules
  initial begin
    bit outstanding = 0, prev_dok = 0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rstn) begin outstanding = 0; prev_dok = 0; continue; end
      if (data_sram_addr_ok || data_sram_data_ok)
        chk("addr_ok_data_ok_overlap", 32'(data_sram_addr_ok && data_sram_data_ok), 0);
      if (data_sram_data_ok) chk("data_ok_single_cycle", 32'(prev_dok), 0);
      if (data_sram_addr_ok) begin
        chk("addr_ok_while_busy", 32'(outstanding), 0);
        outstanding = 1;
      end
      if (data_sram_data_ok) begin
        dok_cnt++;
        chk("data_ok_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk(t.wr ? "rdata_hold_after_store" : "load_rdata", data_sram_rdata, t.wr ? last_rd : t.rdata);
          if (!t.wr) last_rd = t.rdata;
`ifdef DSRAM_BRIDGE_ERR_EN
          chk("data_sram_err", 32'(data_sram_err), 32'(t.resp[1]));
`endif
        end
        outstanding = 0;
      end
      prev_dok = data_sram_data_ok;
    end
  end

  task automatic issue(input txn_t t, input bit keep, output int n);
    n = 0;
    data_sram_req = 1; data_sram_wr = t.wr; data_sram_size = t.size;
    data_sram_addr = t.addr; data_sram_wstrb = t.wstrb; data_sram_wdata = t.wdata;
    do begin @(negedge clk); n++; end while (!data_sram_addr_ok && n < 300);
    if (!data_sram_addr_ok) chk("addr_ok_timeout", 32'(data_sram_addr_ok), 1);
    else begin
      t.rdata = mem_get(0, t.addr[31:2]);
      if (t.wr) ref_mem[t.addr[31:2]] = merge(t.rdata, t.wdata, t.wstrb);
      txn_q.push_back(t); exp_q.push_back(t); issued++;
    end
    @(posedge clk); #1;
    if (!keep) data_sram_req = 0;
  endtask

  task automatic wait_dok(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!data_sram_data_ok && n < 300);
    if (!data_sram_data_ok) chk("data_ok_timeout", 32'(data_sram_data_ok), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  function automatic txn_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [3:0] s, input logic [31:0] d, input logic [1:0] resp);
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wstrb = s; t.wdata = d; t.resp = resp; t.rdata = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [1:0] sz = 2'($urandom_range(0, 2));
    logic [31:0] a = 32'h1C00_0000 | 32'($urandom_range(0, 63));
    logic [31:0] d = $urandom;
    logic [3:0] s;
    a[1:0] = sz == 2 ? 2'b00 : sz == 1 ? {a[1], 1'b0} : a[1:0];
    d = sz == 0 ? {4{d[7:0]}} : sz == 1 ? {2{d[15:0]}} : d;
    s = sz == 2 ? 4'hF : sz == 1 ? (a[1] ? 4'hC : 4'h3) : 4'(4'b0001 << a[1:0]);
    return mk(1'($urandom), sz, a, s, d, 2'($urandom));
  endfunction

  initial begin
    int n, d0;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {26'd0, arvalid, awvalid, wvalid, rready, bready, data_sram_data_ok}, 0);
    chk("reset_addr_ok", 32'(data_sram_addr_ok), 0);
    chk("reset_rdata", data_sram_rdata, 0);
    @(posedge clk); #1 rstn = 1;

    // minimum-latency word load
    issue(mk(0, 2, 32'h1C00_0100, 4'hF, 0, 2'b00), 0, n);
    chk("load_addr_ok_cycle0", 32'(n), 1);
    wait_dok(n);
    chk("load_latency", 32'(n), 3);
    wait_idle();

    // byte store with awready held off
    aw_cycles = 0; w_cycles = 0; aw_block = 3;
    issue(mk(1, 0, 32'h1C00_0203, 4'b1000, 32'h5A5A_5A5A, 2'b00), 0, n);
    wait_dok(n);
    chk("store_w_cycles", 32'(w_cycles), 1);
    chk("store_aw_cycles", 32'(aw_cycles), 4);
    wait_idle();
    issue(mk(0, 2, 32'h1C00_0200, 4'hF, 0, 2'b00), 0, n);
    wait_idle();

    // back-to-back with req held high
    d0 = dok_cnt;
    issue(mk(0, 2, 32'h1C00_0204, 4'hF, 0, 2'b00), 1, n);
    issue(mk(1, 2, 32'h1C00_0204, 4'hF, 32'h1234_5678, 2'b00), 0, n);
    wait_idle();
    chk("b2b_data_ok_count", 32'(dok_cnt - d0), 2);

    // AR backpressure
    ar_cycles = 0; ar_block = 10;
    issue(mk(0, 2, 32'h1C00_0204, 4'hF, 0, 2'b00), 0, n);
    wait_idle();
    chk("ar_backpressure_cycles", 32'(ar_cycles), 11);

    // error response then OKAY load
    issue(mk(1, 2, 32'h1C00_0208, 4'hF, 32'hCAFE_F00D, 2'b10), 0, n);
    issue(mk(0, 2, 32'h1C00_0208, 4'hF, 0, 2'b00), 0, n);
    wait_idle();

    // reset while waiting for the write response
    b_hold = 1;
    issue(mk(1, 1, 32'h1C00_020E, 4'hC, 32'hBEEF_BEEF, 2'b00), 0, n);
    n = 0;
    while (!bready && n < 100) begin @(negedge clk); n++; end
    chk("reach_wr_resp", 32'(bready), 1);
    @(posedge clk); #1 rstn = 0;
    @(posedge clk); @(negedge clk);
    chk("midreset_valids", {26'd0, arvalid, awvalid, wvalid, rready, bready, data_sram_data_ok}, 0);
    chk("midreset_rdata", data_sram_rdata, 0);
    issued -= exp_q.size(); exp_q.delete(); txn_q.delete(); last_rd = '0;
    @(posedge clk); #1 rstn = 1; b_hold = 0;
    issue(mk(0, 2, 32'h1C00_020C, 4'hF, 0, 2'b00), 0, n);
    chk("addr_ok_after_reset", 32'(n), 1);
    wait_idle();

    // randomized traffic with random stalls and held requests
    rnd = 1;
    for (int i = 0; i < 80; i++) issue(rand_txn(), 1'($urandom), n);
    data_sram_req = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("total_data_ok", 32'(dok_cnt), 32'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
